// File: rtl/tx_scheduler_pkg.sv
// Shared types and constants for the serial transmit scheduler.
// Frame is {stop, data, start}; bit 0 leaves the transmitter first.
package tx_scheduler_pkg;

    localparam int FRAME_W = 10;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic [FRAME_W-1:0] IDLE_FRAME = 10'h3FF;

    typedef logic [FRAME_W-1:0] frame_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SEND  = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_e;

    function automatic frame_t make_frame(input logic [7:0] b);
        return {STOP_BIT, b, START_BIT};
    endfunction

endpackage

// File: rtl/tx_scheduler_if.sv
// Requester and transmitter signals of the scheduler; slave is the scheduler side.
interface tx_scheduler_if
    import tx_scheduler_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic              busy;
    logic              err;
    logic              err_clr;
    frame_t            tx_data;
    logic              tx_load_n;
    logic              tx_enable;
    logic              tx_char_sent;

    modport master (
        output req, req_data, err_clr, tx_char_sent,
        input  ack, busy, err, tx_data, tx_load_n, tx_enable
    );

    modport slave (
        input  req, req_data, err_clr, tx_char_sent,
        output ack, busy, err, tx_data, tx_load_n, tx_enable
    );
endinterface

// File: rtl/tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            vld_o
);
    int k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        k     = 0;
        for (int off = 0; off < NREQ; off++) begin
            k = (int'(ptr_i) + off) % NREQ;
            if (!vld_o && req_i[IW'(k)]) begin
                vld_o          = 1'b1;
                gnt_o[IW'(k)]  = 1'b1;
                idx_o          = IW'(k);
            end
        end
    end
endmodule

// File: rtl/tx_scheduler.sv
// Shares one serial transmitter among NREQ requesters: round-robin grant,
// one-cycle parallel load, SEND with watchdog, one-cycle ack on done/abort.
module tx_scheduler
    import tx_scheduler_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4096
) (
    input logic          clk_i,
    input logic          rst_ni,
    tx_scheduler_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e          state_q;
    logic [IW-1:0]   ptr_q, win_q;
    logic [NREQ-1:0] win_oh_q, ack_q;
    frame_t          frame_q;
    logic [CW-1:0]   cnt_q;
    logic            err_q, busy_q, tx_en_q, load_n_q;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_vld;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            win_oh_q <= '0;
            ack_q    <= '0;
            frame_q  <= IDLE_FRAME;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            tx_en_q  <= 1'b0;
            load_n_q <= 1'b1;
        end else begin
            ack_q <= '0;
            // A later set in the ABORT branch overrides this clear.
            if (bus.err_clr) err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_vld) begin
                        win_q    <= arb_idx;
                        win_oh_q <= arb_gnt;
                        frame_q  <= make_frame(bus.req_data[{arb_idx, 3'b000} +: 8]);
                        load_n_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    load_n_q <= 1'b1;
                    tx_en_q  <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= SEND;
                end
                SEND: begin
                    cnt_q <= cnt_q + CW'(1);
                    // cnt_q==0 is the first SEND cycle, where char_sent is stale.
                    if (cnt_q != '0 && bus.tx_char_sent) begin
                        tx_en_q <= 1'b0;
                        ack_q   <= win_oh_q;
                        state_q <= DONE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        tx_en_q <= 1'b0;
                        ack_q   <= win_oh_q;
                        err_q   <= 1'b1;
                        state_q <= ABORT;
                    end
                end
                DONE, ABORT: begin
                    ptr_q   <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
                    frame_q <= IDLE_FRAME;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.tx_data   = frame_q;
    assign bus.tx_load_n = load_n_q;
    assign bus.tx_enable = tx_en_q;
endmodule

// File: tb/tb_tx_scheduler.sv
// Directed scoreboard bench for tx_scheduler (TIMEOUT=16).
module tb_tx_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    logic [9:0] exp_frame_q[$];
    logic [3:0] exp_ack_q[$];
    // Hand-computed frames for lane bytes A5, 5A, 81, 3C.
    logic [9:0] lane_fr [4] = '{10'h34A, 10'h2B4, 10'h302, 10'h278};

    always #5 clk = ~clk;

    tx_scheduler_if #(.NREQ(4)) bus ();

    tx_scheduler #(.NREQ(4), .TIMEOUT(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_xfer(input int lane);
        exp_frame_q.push_back(lane_fr[lane]);
        exp_ack_q.push_back(4'(1 << lane));
    endtask

    // Monitor: every load strobe and ack pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tx_load_n === 1'b0) begin
                if (exp_frame_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_load: got frame %0h expected none", bus.tx_data);
                end else chk("load_frame", bus.tx_data, exp_frame_q.pop_front());
            end
            if (bus.ack !== 4'b0) begin
                if (exp_ack_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: got %0h expected none", bus.ack);
                end else chk("ack_value", bus.ack, exp_ack_q.pop_front());
            end
        end
    end

    // Acts as the transmitter: optional early char_sent over LOAD and first SEND cycle,
    // then a real char_sent; ack must follow in the next cycle.
    task automatic serve(input logic early, input logic [3:0] exp_ack);
        int t;
        t = 0;
        while (bus.tx_load_n !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (bus.tx_load_n !== 1'b0) begin
            chk("load_wait", bus.tx_load_n, 0);
            return;
        end
        bus.tx_char_sent = early;
        @(negedge clk);
        if (early) begin
            @(negedge clk);
            chk("early_ignored", bus.tx_enable, 1);
        end
        bus.tx_char_sent = 1'b0;
        @(negedge clk);
        bus.tx_char_sent = 1'b1;
        @(negedge clk);
        bus.tx_char_sent = 1'b0;
        chk("serve_ack", bus.ack, exp_ack);
    endtask

    task automatic run_timeout(input logic [3:0] exp_ack);
        int t, n;
        t = 0;
        n = 0;
        do begin
            @(negedge clk);
            t++;
            if (bus.tx_enable) n++;
        end while (bus.ack === 4'b0 && t < 200);
        chk("abort_ack", bus.ack, exp_ack);
        chk("abort_send_cycles", n, 16);
        chk("abort_busy", bus.busy, 1);
    endtask

    initial begin
        bus.req = '0;
        bus.req_data = {8'h3C, 8'h81, 8'h5A, 8'hA5};
        bus.err_clr = 1'b0;
        bus.tx_char_sent = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx_data", bus.tx_data, 10'h3FF);
        chk("rst_load_n", bus.tx_load_n, 1);
        chk("rst_enable", bus.tx_enable, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_err", bus.err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin with all requests held
        expect_xfer(0); expect_xfer(1); expect_xfer(2); expect_xfer(3); expect_xfer(0);
        bus.req = 4'b1111;
        serve(1'b0, 4'b0001);
        serve(1'b0, 4'b0010);
        serve(1'b0, 4'b0100);
        serve(1'b0, 4'b1000);
        serve(1'b0, 4'b0001);
        bus.req = '0;
        @(negedge clk);

        // Single request with latency checks
        expect_xfer(0);
        bus.req = 4'b0001;
        @(negedge clk);
        chk("lat_load_n", bus.tx_load_n, 0);
        chk("lat_busy", bus.busy, 1);
        chk("lat_enable_in_load", bus.tx_enable, 0);
        @(negedge clk);
        chk("lat_enable", bus.tx_enable, 1);
        chk("lat_load_n_high", bus.tx_load_n, 1);
        chk("send_frame_hold", bus.tx_data, 10'h34A);
        @(negedge clk);
        bus.tx_char_sent = 1'b1;
        @(negedge clk);
        bus.tx_char_sent = 1'b0;
        chk("single_ack", bus.ack, 4'b0001);
        bus.req = '0;
        @(negedge clk);
        chk("idle_frame", bus.tx_data, 10'h3FF);
        chk("idle_busy", bus.busy, 0);

        // Early char_sent over LOAD and first SEND cycle is ignored
        expect_xfer(1);
        bus.req = 4'b0010;
        serve(1'b1, 4'b0010);
        bus.req = '0;
        @(negedge clk);

        // Pointer fairness: ptr=2, req 0101 -> 2 then 0, index 3 skipped
        expect_xfer(2); expect_xfer(0);
        bus.req = 4'b0101;
        serve(1'b0, 4'b0100);
        serve(1'b0, 4'b0001);
        bus.req = '0;
        @(negedge clk);

        // Watchdog abort, sticky err, then clear
        expect_xfer(1);
        bus.req = 4'b0010;
        run_timeout(4'b0010);
        chk("abort_err_set", bus.err, 1);
        bus.req = '0;
        repeat (3) @(negedge clk);
        chk("err_sticky", bus.err, 1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("err_cleared", bus.err, 0);

        // Abort with err_clr held: set wins
        expect_xfer(2);
        bus.req = 4'b0100;
        bus.err_clr = 1'b1;
        run_timeout(4'b0100);
        chk("err_set_wins", bus.err, 1);
        bus.err_clr = 1'b0;
        bus.req = '0;
        @(negedge clk);
        chk("err_still_set", bus.err, 1);

        // Reset in SEND: frame abandoned, no ack, rerun restarts at LOAD
        exp_frame_q.push_back(lane_fr[3]);
        expect_xfer(3);
        bus.req = 4'b1000;
        repeat (3) @(negedge clk);
        chk("pre_rst_enable", bus.tx_enable, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_enable", bus.tx_enable, 0);
        chk("rst_mid_load_n", bus.tx_load_n, 1);
        chk("rst_mid_tx_data", bus.tx_data, 10'h3FF);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_ack", bus.ack, 0);
        chk("rst_mid_err", bus.err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        serve(1'b0, 4'b1000);
        bus.req = '0;
        repeat (3) @(negedge clk);

        chk("frames_left", exp_frame_q.size(), 0);
        chk("acks_left", exp_ack_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end
endmodule
